mem_rw_arbiter: RTL
===================

# mem_rw_arbiter

Two-master memory port arbiter inside `rvcpu`. It merges instruction-fetch (IFU) and load/store (LSU) requests onto the core's single `ram_rw_*` port, which the simulation top drives into `RAMHelper`. It runs one access at a time through an IDLE/ISSUE/WAIT state machine, registers all RAM-side outputs, and routes the returned 64-bit data back to the owning master.

## Interface
Parameters:
- `AW`, 64, address width
- `DW`, 64, data width (RAM beat)

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `ifu_req_valid_i`  in  1  IFU read request
- `ifu_req_addr_i`  in  AW  fetch address, 4-byte aligned
- `ifu_req_ready_o`  out  1  IFU request accepted this cycle
- `ifu_resp_valid_o`  out  1  one-cycle pulse, fetch data valid
- `ifu_resp_instr_o`  out  32  selected instruction word
- `lsu_req_valid_i`  in  1  LSU request
- `lsu_req_wen_i`  in  1  1 = store, 0 = load
- `lsu_req_addr_i`  in  AW  byte address
- `lsu_req_wdata_i`  in  DW  store data, lane-aligned
- `lsu_req_wmask_i`  in  8  byte-lane write mask
- `lsu_req_size_i`  in  3  access size code
- `lsu_req_ready_o`  out  1  LSU request accepted this cycle
- `lsu_resp_valid_o`  out  1  one-cycle pulse, load data or store done
- `lsu_resp_data_o`  out  DW  raw 64-bit beat (loads only)
- `ram_rw_cen_o`, `ram_rw_wen_o`  out  1  RAM enable, write enable
- `ram_rw_addr_o`  out  AW  RAM address
- `ram_rw_wdata_o`  out  DW  write data
- `ram_rw_wmask_o`  out  8  byte mask
- `ram_rw_size_o`  out  3  size
- `ram_rw_ready_i`  in  1  RAM completion, one cycle after `cen`
- `ram_rw_data_i`  in  DW  read data, valid with `ready`

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If either request is valid, grant one: `*_req_ready_o` is high combinationally for the winner only.
  - Latch the winner's request fields and owner. Next state is ISSUE.
  - The loser's ready stays low; it holds its request.
- ISSUE: `ram_rw_cen_o`=1 for exactly this cycle with the latched fields. Next state is WAIT.
- WAIT:
  - `cen`=0.
  - On `ram_rw_ready_i`, register `ram_rw_data_i` and pulse the owner's `resp_valid` next cycle. Next state is IDLE.
  - Without `ready`, remain in WAIT indefinitely.
- IFU accesses: `wen`=0, `wmask`=0, `size`=3'b011. `ifu_resp_instr_o` = addr[2] ? data[63:32] : data[31:0], using the latched addr.
- Stores: `lsu_resp_valid_o` pulses; `lsu_resp_data_o` holds its previous value.
- Default priority is fixed, LSU over IFU, so that an in-flight load or store never starves behind fetch.
- `ram_rw_addr_o` is passed through unmodified. Base subtraction is the RAM model's job.

## Timing
- Request accepted in cycle N. `cen` is high in N+1, `ram_rw_ready_i` arrives in N+2, and `resp_valid` is high in N+3.
- The state is IDLE again in N+3, so a new grant is possible in N+3. Throughput is one access per 3 cycles.
- `resp_valid` lasts one cycle. Response data holds until the next response.
- Reset values:
  - state IDLE
  - all `ram_rw_*` outputs 0
  - both `resp_valid` 0, `resp` data 0
  - both `req_ready` 0
- Reset mid-access abandons the access. No response is issued, and `cen` is low in the first post-reset cycle.
- `ram_rw_ready_i` outside WAIT is ignored.
- Request signals must stay stable while valid and not accepted. Withdrawing an unaccepted request is legal.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on each grant.
  - On a simultaneous request, the master not granted last wins.
  - The pointer resets to "IFU last", so the first tie goes to the LSU.
- Undefined: fixed LSU priority, no pointer register.

## Structure
- `defines.v` holds:
  - state encodings `MEM_ARB_IDLE/ISSUE/WAIT`
  - owner codes `MEM_OWNER_IFU/LSU`
  - size constant `MEM_SIZE_D`=3'b011
- One sub-module, `mem_arb_pick`: grant logic plus the optional round-robin pointer. Inputs are both valids and IDLE; outputs are one-hot grants.

## Test plan
- IFU read 0x8000_0004, RAM beat 0x1111_2222_3333_4444 → `cen` at N+1; at N+3 `ifu_resp_valid_o`=1 and `ifu_resp_instr_o`=0x1111_2222.
- LSU store 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0x0F → `cen`=`wen`=1 and `wmask`=0x0F for one cycle; `lsu_resp_valid_o` at N+3; `lsu_resp_data_o` unchanged.
- IFU and LSU valid in the same cycle, fixed priority → LSU served first, IFU granted at N+3, IFU response at N+6.
- Same tie four times with `MEM_ARB_RR_EN` → grants LSU, IFU, LSU, IFU.
- `ram_rw_ready_i` held 0 for 5 cycles in WAIT → `cen` stays 0 and no response; response one cycle after `ready` rises.
- `rst_n`=0 during WAIT → state IDLE, all outputs 0, no `resp_valid` afterwards; a fresh IFU request completes normally.

Source files
------------

// File: rtl/mem_rw_arbiter_pkg.sv
// mem_rw_arbiter_pkg: shared types and constants for the IFU/LSU memory port arbiter.
package mem_rw_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE  = 2'd0,
    MEM_ARB_ISSUE = 2'd1,
    MEM_ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    MEM_OWNER_IFU = 1'b0,
    MEM_OWNER_LSU = 1'b1
  } owner_e;

  // Size code for a full 64-bit beat; every fetch reads a whole beat.
  localparam logic [2:0] MEM_SIZE_D = 3'b011;

  // Select the 32-bit instruction word out of a 64-bit beat by address bit 2.
  function automatic logic [31:0] pick_word(input logic hi, input logic [63:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_rw_arbiter_if.sv
// mem_rw_arbiter_if: IFU, LSU and RAM-side signals of the memory port arbiter.
// slave  = the arbiter's view, master = the view of the masters and RAM model.
interface mem_rw_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          ifu_req_valid_i;
  logic [AW-1:0] ifu_req_addr_i;
  logic          ifu_req_ready_o;
  logic          ifu_resp_valid_o;
  logic [31:0]   ifu_resp_instr_o;

  logic          lsu_req_valid_i;
  logic          lsu_req_wen_i;
  logic [AW-1:0] lsu_req_addr_i;
  logic [DW-1:0] lsu_req_wdata_i;
  logic [7:0]    lsu_req_wmask_i;
  logic [2:0]    lsu_req_size_i;
  logic          lsu_req_ready_o;
  logic          lsu_resp_valid_o;
  logic [DW-1:0] lsu_resp_data_o;

  logic          ram_rw_cen_o;
  logic          ram_rw_wen_o;
  logic [AW-1:0] ram_rw_addr_o;
  logic [DW-1:0] ram_rw_wdata_o;
  logic [7:0]    ram_rw_wmask_o;
  logic [2:0]    ram_rw_size_o;
  logic          ram_rw_ready_i;
  logic [DW-1:0] ram_rw_data_i;

  modport slave (
    input  ifu_req_valid_i, ifu_req_addr_i,
    output ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_instr_o,
    input  lsu_req_valid_i, lsu_req_wen_i, lsu_req_addr_i, lsu_req_wdata_i,
    input  lsu_req_wmask_i, lsu_req_size_i,
    output lsu_req_ready_o, lsu_resp_valid_o, lsu_resp_data_o,
    output ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    output ram_rw_wmask_o, ram_rw_size_o,
    input  ram_rw_ready_i, ram_rw_data_i
  );

  modport master (
    output ifu_req_valid_i, ifu_req_addr_i,
    input  ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_instr_o,
    output lsu_req_valid_i, lsu_req_wen_i, lsu_req_addr_i, lsu_req_wdata_i,
    output lsu_req_wmask_i, lsu_req_size_i,
    input  lsu_req_ready_o, lsu_resp_valid_o, lsu_resp_data_o,
    input  ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    input  ram_rw_wmask_o, ram_rw_size_o,
    output ram_rw_ready_i, ram_rw_data_i
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant selection between IFU and LSU while the arbiter is idle.
// MEM_ARB_RR_EN defined: round-robin on ties with a 1-bit last-grant pointer.
// MEM_ARB_RR_EN undefined: fixed LSU-over-IFU priority, no state.
module mem_arb_pick (
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic idle,
  output logic ifu_gnt,
  output logic lsu_gnt
);

`ifdef MEM_ARB_RR_EN
  // 1 = LSU received the most recent grant; resets to "IFU last" so the first tie goes to LSU.
  logic last_lsu;

  // Tie goes to whichever master was not granted last.
  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (idle) begin
      if (ifu_valid && lsu_valid) begin
        lsu_gnt = ~last_lsu;
        ifu_gnt = last_lsu;
      end else begin
        lsu_gnt = lsu_valid;
        ifu_gnt = ifu_valid;
      end
    end
  end

  // Remember the owner of every grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_lsu <= 1'b0;
    end else if (ifu_gnt || lsu_gnt) begin
      last_lsu <= lsu_gnt;
    end
  end
`else
  // Clock and reset only feed the round-robin pointer.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // LSU always wins so an in-flight load/store never starves behind fetch.
  always_comb begin
    lsu_gnt = idle && lsu_valid;
    ifu_gnt = idle && ifu_valid && !lsu_valid;
  end
`endif

endmodule

// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: merges IFU fetches and LSU loads/stores onto the single ram_rw port.
// One access at a time through IDLE -> ISSUE -> WAIT; all RAM-side outputs registered.
// Optional MEM_ARB_RR_EN selects round-robin arbitration inside mem_arb_pick.
module mem_rw_arbiter
  import mem_rw_arbiter_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input logic             clk,
  input logic             rst_n,
  mem_rw_arbiter_if.slave bus
);

  arb_state_e    state;
  owner_e        owner;
  logic          idle;
  logic          ifu_gnt;
  logic          lsu_gnt;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wmask;
  logic [2:0]    req_size;

  // Gating with rst_n keeps both readies low while reset is held, even though
  // state only returns to IDLE on the reset edge.
  assign idle = rst_n && (state == MEM_ARB_IDLE);

  mem_arb_pick u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifu_valid (bus.ifu_req_valid_i),
    .lsu_valid (bus.lsu_req_valid_i),
    .idle      (idle),
    .ifu_gnt   (ifu_gnt),
    .lsu_gnt   (lsu_gnt)
  );

  assign bus.ifu_req_ready_o = ifu_gnt;
  assign bus.lsu_req_ready_o = lsu_gnt;

  // Request fields of the winning master; a fetch is always a full-beat read.
  always_comb begin
    req_wen   = 1'b0;
    req_addr  = bus.ifu_req_addr_i;
    req_wdata = '0;
    req_wmask = '0;
    req_size  = MEM_SIZE_D;
    if (lsu_gnt) begin
      req_wen   = bus.lsu_req_wen_i;
      req_addr  = bus.lsu_req_addr_i;
      req_wdata = bus.lsu_req_wdata_i;
      req_wmask = bus.lsu_req_wmask_i;
      req_size  = bus.lsu_req_size_i;
    end
  end

  // Access sequencer: latch the grant, pulse cen once, wait for ready, respond to the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= MEM_ARB_IDLE;
      owner                <= MEM_OWNER_IFU;
      bus.ram_rw_cen_o     <= 1'b0;
      bus.ram_rw_wen_o     <= 1'b0;
      bus.ram_rw_addr_o    <= '0;
      bus.ram_rw_wdata_o   <= '0;
      bus.ram_rw_wmask_o   <= '0;
      bus.ram_rw_size_o    <= '0;
      bus.ifu_resp_valid_o <= 1'b0;
      bus.ifu_resp_instr_o <= '0;
      bus.lsu_resp_valid_o <= 1'b0;
      bus.lsu_resp_data_o  <= '0;
    end else begin
      bus.ifu_resp_valid_o <= 1'b0;
      bus.lsu_resp_valid_o <= 1'b0;
      case (state)
        MEM_ARB_IDLE: begin
          if (ifu_gnt || lsu_gnt) begin
            bus.ram_rw_cen_o   <= 1'b1;
            bus.ram_rw_wen_o   <= req_wen;
            bus.ram_rw_addr_o  <= req_addr;
            bus.ram_rw_wdata_o <= req_wdata;
            bus.ram_rw_wmask_o <= req_wmask;
            bus.ram_rw_size_o  <= req_size;
            owner              <= lsu_gnt ? MEM_OWNER_LSU : MEM_OWNER_IFU;
            state              <= MEM_ARB_ISSUE;
          end
        end
        MEM_ARB_ISSUE: begin
          bus.ram_rw_cen_o <= 1'b0;
          state            <= MEM_ARB_WAIT;
        end
        MEM_ARB_WAIT: begin
          if (bus.ram_rw_ready_i) begin
            state <= MEM_ARB_IDLE;
            if (owner == MEM_OWNER_LSU) begin
              bus.lsu_resp_valid_o <= 1'b1;
              if (!bus.ram_rw_wen_o) begin
                bus.lsu_resp_data_o <= bus.ram_rw_data_i;
              end
            end else begin
              bus.ifu_resp_valid_o <= 1'b1;
              bus.ifu_resp_instr_o <= pick_word(bus.ram_rw_addr_o[2], bus.ram_rw_data_i);
            end
          end
        end
        default: begin
          state <= MEM_ARB_IDLE;
        end
      endcase
    end
  end

endmodule
